// File: rtl/tank_game_pkg.sv
// Shared tank-game types and screen/tank constants.
// Used by the bullet, eagle and tank modules.
package tank_game_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLYING  = 2'd1,
    EXPLODE = 2'd2
  } bullet_state_t;

  localparam int H_MAX     = 640;
  localparam int V_MAX     = 480;
  localparam int TANK_SIZE = 32;

  localparam logic [9:0] PARK_XY = 10'h3FF;

endpackage

// File: rtl/tank_bullet_if.sv
// Bullet bundle: tank/VGA-side inputs and bullet outputs.
// master = game/VGA side, slave = the bullet owner.
interface tank_bullet_if;
  import tank_game_pkg::*;

  logic [9:0] x;
  logic [9:0] y;
  logic       refresh_tick;
  logic       fire;
  logic [9:0] x_tank;
  logic [9:0] y_tank;
  logic [1:0] dir;
  logic       hit;
  logic [9:0] x_bullet;
  logic [9:0] y_bullet;
  logic       bullet_active;
  logic       bullet_on;
  logic       explode_on;

  modport master (
    output x, y, refresh_tick, fire,
    output x_tank, y_tank, dir, hit,
    input  x_bullet, y_bullet,
    input  bullet_active, bullet_on, explode_on
  );

  modport slave (
    input  x, y, refresh_tick, fire,
    input  x_tank, y_tank, dir, hit,
    output x_bullet, y_bullet,
    output bullet_active, bullet_on, explode_on
  );

endinterface

// File: rtl/tank_bullet.sv
// One tank projectile: launch, flight, edge/hit stop, explosion.
// Coordinate math is done 11 bits wide so off-screen is never wrapped.
module tank_bullet
  import tank_game_pkg::*;
#(
  parameter int BULLET_SPEED   = 4,
  parameter int BULLET_SIZE    = 4,
  parameter int EXPLODE_FRAMES = 8
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  tank_bullet_if.slave bus
);

  localparam int CW = $clog2(EXPLODE_FRAMES + 1);

  localparam logic [10:0] HALF = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [10:0] BS   = 11'(BULLET_SIZE);
  localparam logic [10:0] TS   = 11'(TANK_SIZE);
  localparam logic [10:0] SP   = 11'(BULLET_SPEED);
  localparam logic [10:0] HM   = 11'(H_MAX);
  localparam logic [10:0] VM   = 11'(V_MAX);
  localparam logic [10:0] HLIM = 11'(H_MAX - BULLET_SIZE);
  localparam logic [10:0] VLIM = 11'(V_MAX - BULLET_SIZE);
  localparam logic [10:0] PAD  = 11'((8 - BULLET_SIZE) / 2);
  localparam logic [10:0] EXW  = 11'd8;

  bullet_state_t state;
  dir_t          dir_q;
  logic [9:0]    xb, yb;
  logic [CW-1:0] cnt;

  logic [10:0] xt, yt, xb11, yb11, px, py;
  logic [10:0] lx, ly;
  logic        launch_ok;
  logic [9:0]  mx, my;
  logic        off_edge;
  logic        last_frame;
  logic [10:0] ex_lo, ey_lo;

  assign xt   = {1'b0, bus.x_tank};
  assign yt   = {1'b0, bus.y_tank};
  assign xb11 = {1'b0, xb};
  assign yb11 = {1'b0, yb};
  assign px   = {1'b0, bus.x};
  assign py   = {1'b0, bus.y};

  // Launch point centred on the muzzle side
  always_comb begin
    lx = xt + HALF;
    ly = yt + HALF;
    unique case (dir_t'(bus.dir))
      UP:    ly = yt - BS;
      DOWN:  ly = yt + TS;
      LEFT:  lx = xt - BS;
      RIGHT: lx = xt + TS;
    endcase
  end

  // Underflow sets bit 10, so it also fails these limits
  assign launch_ok = (lx <= HLIM) && (ly <= VLIM);

  always_comb begin
    mx       = xb;
    my       = yb;
    off_edge = 1'b0;
    unique case (dir_q)
      UP: begin
        off_edge = yb11 < SP;
        my       = yb - SP[9:0];
      end
      DOWN: begin
        off_edge = yb11 + BS + SP > VM;
        my       = yb + SP[9:0];
      end
      LEFT: begin
        off_edge = xb11 < SP;
        mx       = xb - SP[9:0];
      end
      RIGHT: begin
        off_edge = xb11 + BS + SP > HM;
        mx       = xb + SP[9:0];
      end
    endcase
  end

  assign last_frame = cnt == CW'(EXPLODE_FRAMES - 1);

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      xb    <= PARK_XY;
      yb    <= PARK_XY;
      dir_q <= UP;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.fire && launch_ok) begin
            xb    <= lx[9:0];
            yb    <= ly[9:0];
            dir_q <= dir_t'(bus.dir);
            state <= FLYING;
          end
        end
        FLYING: begin
          if (bus.hit) begin
            state <= EXPLODE;
          end else if (bus.refresh_tick) begin
            if (off_edge) begin
              state <= EXPLODE;
            end else begin
              xb <= mx;
              yb <= my;
            end
          end
        end
        EXPLODE: begin
          if (bus.refresh_tick && last_frame) begin
            state <= IDLE;
            xb    <= PARK_XY;
            yb    <= PARK_XY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == EXPLODE && bus.refresh_tick) begin
      cnt <= last_frame ? '0 : cnt + 1'b1;
    end
  end

  // Explosion box is clipped at the top/left screen edge
  assign ex_lo = (xb11 < PAD) ? 11'd0 : xb11 - PAD;
  assign ey_lo = (yb11 < PAD) ? 11'd0 : yb11 - PAD;

  assign bus.x_bullet      = xb;
  assign bus.y_bullet      = yb;
  assign bus.bullet_active = state == FLYING;

  assign bus.bullet_on = (state == FLYING)
                      && px >= xb11 && px < xb11 + BS
                      && py >= yb11 && py < yb11 + BS;

  assign bus.explode_on = (state == EXPLODE)
                       && px >= ex_lo && px < xb11 - PAD + EXW
                       && py >= ey_lo && py < yb11 - PAD + EXW;

endmodule

// File: tb/tb_tank_bullet.sv
// Bench for tank_bullet: integer reference model, per-cycle compare,
// directed scenarios with literal pins, then randomized traffic.
module tb_tank_bullet;
  import tank_game_pkg::*;

  logic clk_50MHz = 1'b0;
  logic reset     = 1'b1;

  tank_bullet_if bus();

  tank_bullet dut (
    .clk_50MHz(clk_50MHz),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  // model: 0 idle, 1 flying, 2 exploding; plain signed integers
  int m_st  = 0;
  int m_x   = 1023;
  int m_y   = 1023;
  int m_dir = 0;
  int m_cnt = 0;
  int lx, ly, nx, ny;

  task automatic check(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit inside_rng(int p, int lo, int hi);
    return p >= lo && p < hi;
  endfunction

  function automatic int max0(int v);
    return v < 0 ? 0 : v;
  endfunction

  function automatic bit on_screen(int bx, int by);
    return bx >= 0 && by >= 0 && bx + 4 <= 640 && by + 4 <= 480;
  endfunction

  always @(posedge clk_50MHz) begin
    if (reset) begin
      m_st = 0; m_x = 1023; m_y = 1023; m_dir = 0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (bus.fire) begin
        lx = int'(bus.x_tank) + 14;
        ly = int'(bus.y_tank) + 14;
        case (int'(bus.dir))
          0: ly = int'(bus.y_tank) - 4;
          1: lx = int'(bus.x_tank) + 32;
          2: ly = int'(bus.y_tank) + 32;
          default: lx = int'(bus.x_tank) - 4;
        endcase
        if (on_screen(lx, ly)) begin
          m_x = lx; m_y = ly; m_dir = int'(bus.dir); m_st = 1;
        end
      end
    end else if (m_st == 1) begin
      if (bus.hit) begin
        m_st = 2;
      end else if (bus.refresh_tick) begin
        nx = m_x + (m_dir == 1 ? 4 : m_dir == 3 ? -4 : 0);
        ny = m_y + (m_dir == 2 ? 4 : m_dir == 0 ? -4 : 0);
        if (on_screen(nx, ny)) begin
          m_x = nx; m_y = ny;
        end else begin
          m_st = 2;
        end
      end
    end else begin
      if (bus.refresh_tick) begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_st = 0; m_cnt = 0; m_x = 1023; m_y = 1023;
        end
      end
    end
  end

  always @(negedge clk_50MHz) begin
    if (checking) begin
      check("x_bullet", int'(bus.x_bullet), m_x);
      check("y_bullet", int'(bus.y_bullet), m_y);
      check("bullet_active", int'(bus.bullet_active), int'(m_st == 1));
      check("bullet_on", int'(bus.bullet_on),
            int'(m_st == 1
                 && inside_rng(int'(bus.x), m_x, m_x + 4)
                 && inside_rng(int'(bus.y), m_y, m_y + 4)));
      check("explode_on", int'(bus.explode_on),
            int'(m_st == 2
                 && inside_rng(int'(bus.x), max0(m_x - 2), m_x + 6)
                 && inside_rng(int'(bus.y), max0(m_y - 2), m_y + 6)));
    end
  end

  task automatic nxt();
    @(negedge clk_50MHz);
    #1;
  endtask

  task automatic pin(string name, int ex, int ey, int act);
    check({name, "_x"}, int'(bus.x_bullet), ex);
    check({name, "_y"}, int'(bus.y_bullet), ey);
    check({name, "_active"}, int'(bus.bullet_active), act);
    check({name, "_model_x"}, m_x, ex);
    check({name, "_model_y"}, m_y, ey);
  endtask

  task automatic launch(int tx, int ty, int d);
    bus.x_tank = 10'(tx);
    bus.y_tank = 10'(ty);
    bus.dir    = 2'(d);
    bus.fire   = 1'b1;
    nxt();
    bus.fire   = 1'b0;
  endtask

  task automatic ticks(int n);
    repeat (n) begin
      bus.refresh_tick = 1'b1;
      nxt();
      bus.refresh_tick = 1'b0;
      nxt();
    end
  endtask

  task automatic hit_once();
    bus.hit = 1'b1;
    nxt();
    bus.hit = 1'b0;
  endtask

  initial begin
    int px, py;
    bus.x = '0; bus.y = '0; bus.refresh_tick = 1'b0;
    bus.fire = 1'b1; bus.x_tank = '0; bus.y_tank = '0;
    bus.dir = '0; bus.hit = 1'b0;
    nxt();
    nxt();
    checking = 1'b1;
    pin("reset", 1023, 1023, 0);
    reset = 1'b0;
    bus.fire = 1'b0;
    nxt();

    launch(300, 300, 0);
    pin("launch_up", 314, 296, 1);
    ticks(3);
    pin("move_up", 314, 284, 1);
    hit_once();
    pin("hit_freeze", 314, 284, 0);
    ticks(8);
    pin("explode_done", 1023, 1023, 0);

    launch(300, 2, 0);
    pin("underflow", 1023, 1023, 0);

    bus.x = 10'd312;
    bus.y = 10'd472;
    launch(300, 442, 2);
    pin("launch_down", 314, 474, 1);
    bus.refresh_tick = 1'b1;
    nxt();
    bus.refresh_tick = 1'b0;
    pin("edge_down", 314, 474, 0);
    for (int i = 0; i < 8; i++) begin
      check("explode_pixel", int'(bus.explode_on), 1);
      ticks(1);
    end
    pin("down_done", 1023, 1023, 0);
    check("explode_pixel_off", int'(bus.explode_on), 0);

    launch(368, 236, 1);
    pin("launch_right", 400, 250, 1);
    bus.hit = 1'b1;
    bus.refresh_tick = 1'b1;
    nxt();
    bus.hit = 1'b0;
    bus.refresh_tick = 1'b0;
    pin("hit_and_tick", 400, 250, 0);
    bus.fire = 1'b1;
    nxt();
    pin("fire_in_explode", 400, 250, 0);
    ticks(8);
    pin("held_relaunch", 400, 250, 1);
    bus.fire = 1'b0;
    hit_once();
    ticks(8);

    launch(86, 204, 0);
    pin("launch_mid", 100, 200, 1);
    reset = 1'b1;
    bus.fire = 1'b1;
    nxt();
    pin("reset_mid", 1023, 1023, 0);
    reset = 1'b0;
    bus.fire = 1'b0;
    nxt();
    pin("after_reset", 1023, 1023, 0);

    launch(86, 104, 0);
    pin("launch_scan", 100, 100, 1);
    for (int xi = 97; xi <= 106; xi++) begin
      for (int yi = 97; yi <= 106; yi++) begin
        bus.x = 10'(xi);
        bus.y = 10'(yi);
        nxt();
        if (yi == 100 && (xi == 99 || xi == 104))
          check("bullet_on_edge", int'(bus.bullet_on), 0);
        if (xi >= 100 && xi <= 103 && yi >= 100 && yi <= 103)
          check("bullet_on_in", int'(bus.bullet_on), 1);
      end
    end
    hit_once();
    ticks(8);

    for (int c = 0; c < 6000; c++) begin
      bus.refresh_tick = ($urandom_range(0, 3) == 0);
      bus.fire = ($urandom_range(0, 7) == 0);
      bus.hit  = ($urandom_range(0, 60) == 0);
      reset    = ($urandom_range(0, 2499) == 0);
      if ($urandom_range(0, 15) == 0) begin
        bus.dir    = 2'($urandom_range(0, 3));
        bus.x_tank = 10'($urandom_range(0, 660));
        bus.y_tank = 10'($urandom_range(0, 500));
      end
      if ($urandom_range(0, 1) == 0) begin
        px = m_x - 3 + int'($urandom_range(0, 10));
        py = m_y - 3 + int'($urandom_range(0, 10));
        bus.x = 10'(px < 0 ? 0 : px > 1023 ? 1023 : px);
        bus.y = 10'(py < 0 ? 0 : py > 1023 ? 1023 : py);
      end else begin
        bus.x = 10'($urandom_range(0, 1023));
        bus.y = 10'($urandom_range(0, 1023));
      end
      nxt();
    end
    reset = 1'b0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
